// File: rtl/islec_toplayici.sv
// Single-entry operand collector: holds one decoded uop, gathers both source operands
// from the register file, then dispatches to execute and assigns a tag to rd.
module islec_toplayici #(
   parameter int VERI_BIT    = 32,
   parameter int YAZMAC_BIT  = 5,
   parameter int UOP_TAG_BIT = 4,
   parameter int UOP_BIT     = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   temizle_i,
   input  logic                   giris_gecerli_i,
   output logic                   giris_hazir_o,
   input  logic [YAZMAC_BIT-1:0]  giris_rs1_i,
   input  logic [YAZMAC_BIT-1:0]  giris_rs2_i,
   input  logic [YAZMAC_BIT-1:0]  giris_rd_i,
   input  logic                   giris_rd_gecerli_i,
   input  logic [UOP_BIT-1:0]     giris_uop_i,
   output logic [YAZMAC_BIT-1:0]  oku_adres1_o,
   output logic [YAZMAC_BIT-1:0]  oku_adres2_o,
   input  logic [VERI_BIT-1:0]    oku_veri1_i,
   input  logic                   oku_veri1_gecerli_i,
   input  logic [VERI_BIT-1:0]    oku_veri2_i,
   input  logic                   oku_veri2_gecerli_i,
   output logic [UOP_TAG_BIT-1:0] etiket_o,
   output logic [YAZMAC_BIT-1:0]  etiket_adres_o,
   output logic                   etiket_gecerli_o,
   output logic                   cikis_gecerli_o,
   input  logic                   cikis_hazir_i,
   output logic [UOP_BIT-1:0]     cikis_uop_o,
   output logic [VERI_BIT-1:0]    cikis_islec1_o,
   output logic [VERI_BIT-1:0]    cikis_islec2_o,
   output logic [YAZMAC_BIT-1:0]  cikis_rd_o,
   output logic                   cikis_rd_gecerli_o,
   output logic [UOP_TAG_BIT-1:0] cikis_etiket_o
);

   typedef enum logic [1:0] {BOS, BEKLE, HAZIR} durum_t;

   durum_t durum_q, durum_d;

   logic [YAZMAC_BIT-1:0]  rs1_p0, rs2_p0, rd_p0;
   logic                   rd_gecerli_p0;
   logic [UOP_BIT-1:0]     uop_p0;
   logic [VERI_BIT-1:0]    islec1_p1, islec2_p1;
   logic                   vld1_p1, vld2_p1;
   logic [UOP_TAG_BIT-1:0] sayac_q;

   logic kabul, tokalasma, al1, al2;

   // x0 reads as zero regardless of what the register file drives
   function automatic logic [VERI_BIT-1:0] islec_sec(input logic [YAZMAC_BIT-1:0] adres,
                                                     input logic [VERI_BIT-1:0]   veri);
      return (adres == '0) ? '0 : veri;
   endfunction

   always_comb begin
      kabul     = (durum_q == BOS) && giris_gecerli_i && !temizle_i;
      tokalasma = (durum_q == HAZIR) && cikis_hazir_i;
      al1       = (durum_q == BEKLE) && !vld1_p1 && (oku_veri1_gecerli_i || rs1_p0 == '0);
      al2       = (durum_q == BEKLE) && !vld2_p1 && (oku_veri2_gecerli_i || rs2_p0 == '0);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) durum_q <= BOS;
      else       durum_q <= durum_d;
   end

   always_comb begin
      durum_d = durum_q;
      case (durum_q)
         BOS:     if (giris_gecerli_i) durum_d = BEKLE;
         BEKLE:   if ((vld1_p1 || al1) && (vld2_p1 || al2)) durum_d = HAZIR;
         HAZIR:   if (cikis_hazir_i) durum_d = BOS;
         default: durum_d = BOS;
      endcase
      if (temizle_i) durum_d = BOS;
   end

   // Stage p0: uop fields latched on accept
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rs1_p0        <= '0;
         rs2_p0        <= '0;
         rd_p0         <= '0;
         rd_gecerli_p0 <= 1'b0;
         uop_p0        <= '0;
      end else if (kabul) begin
         rs1_p0        <= giris_rs1_i;
         rs2_p0        <= giris_rs2_i;
         rd_p0         <= giris_rd_i;
         rd_gecerli_p0 <= giris_rd_gecerli_i;
         uop_p0        <= giris_uop_i;
      end
   end

   // Stage p1: operands captured once each, in any order
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         islec1_p1 <= '0;
         islec2_p1 <= '0;
         vld1_p1   <= 1'b0;
         vld2_p1   <= 1'b0;
      end else if (temizle_i || kabul) begin
         vld1_p1 <= 1'b0;
         vld2_p1 <= 1'b0;
      end else begin
         if (al1) begin
            islec1_p1 <= islec_sec(rs1_p0, oku_veri1_i);
            vld1_p1   <= 1'b1;
         end
         if (al2) begin
            islec2_p1 <= islec_sec(rs2_p0, oku_veri2_i);
            vld2_p1   <= 1'b1;
         end
      end
   end

   // Tag is allocated at dispatch so rd==rs never waits on its own pending tag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                 sayac_q <= '0;
      else if (etiket_gecerli_o) sayac_q <= sayac_q + 1'b1;
   end

   assign etiket_gecerli_o   = tokalasma && rd_gecerli_p0 && (rd_p0 != '0) && !temizle_i;
   assign etiket_o           = sayac_q;
   assign etiket_adres_o     = rd_p0;
   assign giris_hazir_o      = (durum_q == BOS);
   assign cikis_gecerli_o    = (durum_q == HAZIR);
   assign oku_adres1_o       = rs1_p0;
   assign oku_adres2_o       = rs2_p0;
   assign cikis_uop_o        = uop_p0;
   assign cikis_islec1_o     = islec1_p1;
   assign cikis_islec2_o     = islec2_p1;
   assign cikis_rd_o         = rd_p0;
   assign cikis_rd_gecerli_o = rd_gecerli_p0;
   assign cikis_etiket_o     = sayac_q;

endmodule

// File: tb/tb_islec_toplayici.sv
// Directed bench for islec_toplayici: accept, operand capture, dispatch, tagging, flush, reset.
module tb_islec_toplayici;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        temizle_i = 1'b0;
   logic        giris_gecerli_i = 1'b0;
   logic        giris_hazir_o;
   logic [4:0]  giris_rs1_i = '0, giris_rs2_i = '0, giris_rd_i = '0;
   logic        giris_rd_gecerli_i = 1'b0;
   logic [31:0] giris_uop_i = '0;
   logic [4:0]  oku_adres1_o, oku_adres2_o;
   logic [31:0] oku_veri1_i = '0, oku_veri2_i = '0;
   logic        oku_veri1_gecerli_i = 1'b0, oku_veri2_gecerli_i = 1'b0;
   logic [3:0]  etiket_o;
   logic [4:0]  etiket_adres_o;
   logic        etiket_gecerli_o;
   logic        cikis_gecerli_o;
   logic        cikis_hazir_i = 1'b0;
   logic [31:0] cikis_uop_o, cikis_islec1_o, cikis_islec2_o;
   logic [4:0]  cikis_rd_o;
   logic        cikis_rd_gecerli_o;
   logic [3:0]  cikis_etiket_o;

   int checks = 0;
   int errors = 0;

   islec_toplayici #(.VERI_BIT(32), .YAZMAC_BIT(5), .UOP_TAG_BIT(4), .UOP_BIT(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .temizle_i(temizle_i),
      .giris_gecerli_i(giris_gecerli_i), .giris_hazir_o(giris_hazir_o),
      .giris_rs1_i(giris_rs1_i), .giris_rs2_i(giris_rs2_i), .giris_rd_i(giris_rd_i),
      .giris_rd_gecerli_i(giris_rd_gecerli_i), .giris_uop_i(giris_uop_i),
      .oku_adres1_o(oku_adres1_o), .oku_adres2_o(oku_adres2_o),
      .oku_veri1_i(oku_veri1_i), .oku_veri1_gecerli_i(oku_veri1_gecerli_i),
      .oku_veri2_i(oku_veri2_i), .oku_veri2_gecerli_i(oku_veri2_gecerli_i),
      .etiket_o(etiket_o), .etiket_adres_o(etiket_adres_o), .etiket_gecerli_o(etiket_gecerli_o),
      .cikis_gecerli_o(cikis_gecerli_o), .cikis_hazir_i(cikis_hazir_i),
      .cikis_uop_o(cikis_uop_o), .cikis_islec1_o(cikis_islec1_o), .cikis_islec2_o(cikis_islec2_o),
      .cikis_rd_o(cikis_rd_o), .cikis_rd_gecerli_o(cikis_rd_gecerli_o),
      .cikis_etiket_o(cikis_etiket_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic adim();
      @(posedge clk_i);
      #1;
   endtask

   task automatic kabul_et(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                           input logic rdg, input logic [31:0] u);
      giris_rs1_i = r1; giris_rs2_i = r2; giris_rd_i = rd;
      giris_rd_gecerli_i = rdg; giris_uop_i = u; giris_gecerli_i = 1'b1;
      adim();
      giris_gecerli_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      #1 rst_i = 1'b1;
      #1;
      checks++; if (giris_hazir_o !== 1'b1) begin errors++; $display("FAIL rst_hazir got %b exp 1", giris_hazir_o); end
      checks++; if (cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL rst_cikis_vld got %b exp 0", cikis_gecerli_o); end
      checks++; if (etiket_gecerli_o !== 1'b0) begin errors++; $display("FAIL rst_etiket_vld got %b exp 0", etiket_gecerli_o); end
      checks++; if (oku_adres1_o !== 5'd0 || oku_adres2_o !== 5'd0) begin errors++; $display("FAIL rst_adres got %0d/%0d exp 0/0", oku_adres1_o, oku_adres2_o); end
      checks++; if (cikis_etiket_o !== 4'd0) begin errors++; $display("FAIL rst_sayac got %0d exp 0", cikis_etiket_o); end
      adim(); adim();
      rst_i = 1'b0;
      adim();
   endtask

   task automatic test_temel();
      oku_veri1_i = 32'hA5; oku_veri1_gecerli_i = 1'b1;
      oku_veri2_i = 32'h5A; oku_veri2_gecerli_i = 1'b1;
      kabul_et(5'd3, 5'd4, 5'd5, 1'b1, 32'h1111_0001);
      checks++; if (oku_adres1_o !== 5'd3 || oku_adres2_o !== 5'd4) begin errors++; $display("FAIL temel_adres got %0d/%0d exp 3/4", oku_adres1_o, oku_adres2_o); end
      checks++; if (giris_hazir_o !== 1'b0) begin errors++; $display("FAIL temel_hazir_bekle got %b exp 0", giris_hazir_o); end
      checks++; if (cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL temel_erken_vld got %b exp 0", cikis_gecerli_o); end
      adim();
      checks++; if (cikis_gecerli_o !== 1'b1) begin errors++; $display("FAIL temel_vld got %b exp 1", cikis_gecerli_o); end
      checks++; if (cikis_islec1_o !== 32'hA5 || cikis_islec2_o !== 32'h5A) begin errors++; $display("FAIL temel_islec got %h/%h exp a5/5a", cikis_islec1_o, cikis_islec2_o); end
      checks++; if (cikis_uop_o !== 32'h1111_0001 || cikis_rd_o !== 5'd5 || cikis_rd_gecerli_o !== 1'b1) begin errors++; $display("FAIL temel_uop got %h rd %0d/%b exp 11110001 rd 5/1", cikis_uop_o, cikis_rd_o, cikis_rd_gecerli_o); end
      checks++; if (etiket_gecerli_o !== 1'b0) begin errors++; $display("FAIL temel_etiket_erken got %b exp 0", etiket_gecerli_o); end
      cikis_hazir_i = 1'b1;
      #1;
      checks++; if (etiket_gecerli_o !== 1'b1 || etiket_adres_o !== 5'd5 || etiket_o !== 4'd0) begin errors++; $display("FAIL temel_etiket got %b adr %0d tag %0d exp 1 adr 5 tag 0", etiket_gecerli_o, etiket_adres_o, etiket_o); end
      adim();
      cikis_hazir_i = 1'b0;
      #1;
      checks++; if (giris_hazir_o !== 1'b1 || cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL temel_bos got hazir %b vld %b exp 1/0", giris_hazir_o, cikis_gecerli_o); end
      checks++; if (cikis_etiket_o !== 4'd1) begin errors++; $display("FAIL temel_sayac got %0d exp 1", cikis_etiket_o); end
   endtask

   task automatic test_bekleme();
      oku_veri1_i = 32'h0; oku_veri1_gecerli_i = 1'b0;
      oku_veri2_i = 32'hFFFF; oku_veri2_gecerli_i = 1'b0;
      kabul_et(5'd7, 5'd0, 5'd2, 1'b1, 32'h2222_0002);
      for (int i = 0; i < 4; i++) begin
         checks++; if (cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL bekle_vld_%0d got %b exp 0", i, cikis_gecerli_o); end
         adim();
      end
      oku_veri1_i = 32'h1234; oku_veri1_gecerli_i = 1'b1;
      #1;
      checks++; if (cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL bekle_vld_yukselis got %b exp 0", cikis_gecerli_o); end
      adim();
      oku_veri1_i = 32'h9999;
      #1;
      checks++; if (cikis_gecerli_o !== 1'b1) begin errors++; $display("FAIL bekle_vld got %b exp 1", cikis_gecerli_o); end
      checks++; if (cikis_islec1_o !== 32'h1234 || cikis_islec2_o !== 32'h0) begin errors++; $display("FAIL bekle_islec got %h/%h exp 1234/0", cikis_islec1_o, cikis_islec2_o); end
      cikis_hazir_i = 1'b1;
      #1;
      checks++; if (etiket_gecerli_o !== 1'b1 || etiket_adres_o !== 5'd2 || etiket_o !== 4'd1) begin errors++; $display("FAIL bekle_etiket got %b adr %0d tag %0d exp 1 adr 2 tag 1", etiket_gecerli_o, etiket_adres_o, etiket_o); end
      adim();
      cikis_hazir_i = 1'b0;
      oku_veri1_gecerli_i = 1'b0;
   endtask

   task automatic test_sifir();
      oku_veri1_i = 32'hDEAD; oku_veri1_gecerli_i = 1'b0;
      oku_veri2_i = 32'hBEEF; oku_veri2_gecerli_i = 1'b0;
      kabul_et(5'd0, 5'd0, 5'd0, 1'b1, 32'h3333_0003);
      adim();
      checks++; if (cikis_gecerli_o !== 1'b1) begin errors++; $display("FAIL sifir_vld got %b exp 1", cikis_gecerli_o); end
      checks++; if (cikis_islec1_o !== 32'h0 || cikis_islec2_o !== 32'h0) begin errors++; $display("FAIL sifir_islec got %h/%h exp 0/0", cikis_islec1_o, cikis_islec2_o); end
      cikis_hazir_i = 1'b1;
      #1;
      checks++; if (etiket_gecerli_o !== 1'b0) begin errors++; $display("FAIL sifir_etiket got %b exp 0", etiket_gecerli_o); end
      adim();
      cikis_hazir_i = 1'b0;
      #1;
      checks++; if (cikis_etiket_o !== 4'd2 || giris_hazir_o !== 1'b1) begin errors++; $display("FAIL sifir_sayac got %0d hazir %b exp 2 hazir 1", cikis_etiket_o, giris_hazir_o); end
   endtask

   task automatic test_dondurma();
      oku_veri1_i = 32'h11; oku_veri1_gecerli_i = 1'b1;
      oku_veri2_i = 32'h22; oku_veri2_gecerli_i = 1'b1;
      kabul_et(5'd3, 5'd4, 5'd3, 1'b1, 32'hDEAD_BEEF);
      adim();
      for (int i = 0; i < 3; i++) begin
         oku_veri1_i = $urandom | 32'h100; oku_veri2_i = $urandom | 32'h100;
         giris_rs1_i = 5'd9; giris_gecerli_i = 1'b1;
         adim();
         checks++; if (cikis_gecerli_o !== 1'b1 || giris_hazir_o !== 1'b0) begin errors++; $display("FAIL dondur_durum_%0d got vld %b hazir %b exp 1/0", i, cikis_gecerli_o, giris_hazir_o); end
         checks++; if (cikis_islec1_o !== 32'h11 || cikis_islec2_o !== 32'h22 || cikis_uop_o !== 32'hDEAD_BEEF || oku_adres1_o !== 5'd3) begin errors++; $display("FAIL dondur_veri_%0d got %h/%h/%h adr %0d exp 11/22/deadbeef adr 3", i, cikis_islec1_o, cikis_islec2_o, cikis_uop_o, oku_adres1_o); end
      end
      giris_gecerli_i = 1'b0;
      cikis_hazir_i = 1'b1;
      #1;
      checks++; if (etiket_gecerli_o !== 1'b1 || etiket_adres_o !== 5'd3 || etiket_o !== 4'd2) begin errors++; $display("FAIL dondur_etiket got %b adr %0d tag %0d exp 1 adr 3 tag 2", etiket_gecerli_o, etiket_adres_o, etiket_o); end
      adim();
      cikis_hazir_i = 1'b0;
   endtask

   task automatic test_sarma();
      rst_i = 1'b1;
      #1;
      checks++; if (cikis_etiket_o !== 4'd0) begin errors++; $display("FAIL sarma_rst got %0d exp 0", cikis_etiket_o); end
      adim();
      rst_i = 1'b0;
      oku_veri1_gecerli_i = 1'b1; oku_veri2_gecerli_i = 1'b1;
      for (int i = 0; i < 17; i++) begin
         kabul_et(5'd1, 5'd1, 5'd1, 1'b1, i);
         adim();
         cikis_hazir_i = 1'b1;
         #1;
         checks++; if (etiket_gecerli_o !== 1'b1 || etiket_o !== 4'(i)) begin errors++; $display("FAIL sarma_%0d got %b tag %0d exp 1 tag %0d", i, etiket_gecerli_o, etiket_o, i % 16); end
         adim();
         cikis_hazir_i = 1'b0;
      end
   endtask

   task automatic test_temizle();
      temizle_i = 1'b1;
      giris_rs1_i = 5'd9; giris_gecerli_i = 1'b1;
      adim();
      temizle_i = 1'b0; giris_gecerli_i = 1'b0;
      #1;
      checks++; if (giris_hazir_o !== 1'b1 || oku_adres1_o !== 5'd1) begin errors++; $display("FAIL temizle_bos got hazir %b adr %0d exp 1 adr 1", giris_hazir_o, oku_adres1_o); end
      oku_veri1_gecerli_i = 1'b0;
      kabul_et(5'd5, 5'd0, 5'd6, 1'b1, 32'h4444_0004);
      temizle_i = 1'b1;
      #1;
      checks++; if (etiket_gecerli_o !== 1'b0) begin errors++; $display("FAIL temizle_bekle_etiket got %b exp 0", etiket_gecerli_o); end
      adim();
      temizle_i = 1'b0;
      #1;
      checks++; if (giris_hazir_o !== 1'b1 || cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL temizle_bekle got hazir %b vld %b exp 1/0", giris_hazir_o, cikis_gecerli_o); end
      oku_veri1_gecerli_i = 1'b1;
      kabul_et(5'd5, 5'd0, 5'd6, 1'b1, 32'h5555_0005);
      adim();
      checks++; if (cikis_gecerli_o !== 1'b1) begin errors++; $display("FAIL temizle_hazir_vld got %b exp 1", cikis_gecerli_o); end
      cikis_hazir_i = 1'b1; temizle_i = 1'b1;
      #1;
      checks++; if (etiket_gecerli_o !== 1'b0) begin errors++; $display("FAIL temizle_hazir_etiket got %b exp 0", etiket_gecerli_o); end
      adim();
      cikis_hazir_i = 1'b0; temizle_i = 1'b0;
      #1;
      checks++; if (giris_hazir_o !== 1'b1 || cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL temizle_hazir got hazir %b vld %b exp 1/0", giris_hazir_o, cikis_gecerli_o); end
      checks++; if (cikis_etiket_o !== 4'd1) begin errors++; $display("FAIL temizle_sayac got %0d exp 1", cikis_etiket_o); end
   endtask

   task automatic test_async_reset();
      oku_veri1_gecerli_i = 1'b0;
      kabul_et(5'd8, 5'd9, 5'd4, 1'b1, 32'h6666_0006);
      checks++; if (giris_hazir_o !== 1'b0 || oku_adres1_o !== 5'd8) begin errors++; $display("FAIL arst_once got hazir %b adr %0d exp 0 adr 8", giris_hazir_o, oku_adres1_o); end
      #2 rst_i = 1'b1;
      #1;
      checks++; if (giris_hazir_o !== 1'b1 || oku_adres1_o !== 5'd0 || oku_adres2_o !== 5'd0) begin errors++; $display("FAIL arst_hemen got hazir %b adr %0d/%0d exp 1 adr 0/0", giris_hazir_o, oku_adres1_o, oku_adres2_o); end
      checks++; if (cikis_etiket_o !== 4'd0 || etiket_gecerli_o !== 1'b0) begin errors++; $display("FAIL arst_etiket got %0d/%b exp 0/0", cikis_etiket_o, etiket_gecerli_o); end
      rst_i = 1'b0;
      adim();
      checks++; if (giris_hazir_o !== 1'b1 || cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL arst_sonra got hazir %b vld %b exp 1/0", giris_hazir_o, cikis_gecerli_o); end
   endtask

   initial begin
      test_reset();
      test_temel();
      test_bekleme();
      test_sifir();
      test_dondurma();
      test_sarma();
      test_temizle();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
